// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: FSM states, RV32I load/store funct3 codes,
// and the request legality check (funct3 and alignment; the range check lives in the top).
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_DATA,
    S_WR,
    S_RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int WORD_SHIFT = 2;

  // Unsigned variants only exist for loads, so they are illegal on a store.
  function automatic logic req_bad(input logic we, input logic [2:0] funct3, input logic [1:0] lane);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = lane[0];
      F3_W:    bad = |lane;
      F3_BU:   bad = we;
      F3_HU:   bad = we | lane[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response and data-memory signals of the load/store unit.
// slave is the LSU itself; master is the core plus memory around it.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_trig;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_trig, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_trig, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane datapath: extends a loaded lane and merges a sub-word store into the old word.
// Purely combinational; the caller guarantees alignment.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [4:0]  sh;
  logic [15:0] low;

  assign sh  = {lane, 3'b000};
  assign low = 16'(rdata >> sh);

  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{low[7]}}, low[7:0]};
      F3_H:    load_data = {{16{low[15]}}, low};
      F3_W:    load_data = rdata;
      F3_BU:   load_data = {24'h0, low[7:0]};
      F3_HU:   load_data = {16'h0, low};
      default: load_data = '0;
    endcase
  end

  // Halfword lanes are 0 or 2 here, so the same shift covers bytes and halfwords.
  always_comb begin
    store_word = rdata;
    case (funct3)
      F3_B:    store_word = (rdata & ~(32'h0000_00ff << sh)) | ({24'h0, wdata[7:0]} << sh);
      F3_H:    store_word = (rdata & ~(32'h0000_ffff << sh)) | ({16'h0, wdata[15:0]} << sh);
      F3_W:    store_word = wdata;
      default: store_word = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, sub-word stores by read-modify-write.
// All request-side and memory-side outputs are registered.
//
// state     | meaning
// S_IDLE    | ready for a request
// S_RD_REQ  | read strobe to memory
// S_RD_DATA | memory word arrives; extend for loads, merge for SB/SH
// S_WR      | write strobe with full word
// S_RESP    | one-cycle response pulse
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MEM_WORDS   = 512,
  parameter int RANGE_CHECK = 1
) (
  input logic  clk,
  input logic  reset,
  lsu_if.slave bus
);

  localparam logic [33:0] ADDR_LIMIT = 34'(MEM_WORDS) << WORD_SHIFT;

  state_t           state;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [1:0]       lane_q;
  logic [WIDTH-1:0] wdata_q;
  logic             resp_valid_q;
  logic [WIDTH-1:0] resp_rdata_q;
  logic             resp_err_q;
  logic             mem_trig_q;
  logic             mem_read_q;
  logic             mem_write_q;
  logic [31:0]      mem_addr_q;
  logic [WIDTH-1:0] mem_wdata_q;

  logic             range_err;
  logic             accept_err;
  logic [31:0]      load_data;
  logic [31:0]      store_word;

  assign range_err  = (RANGE_CHECK != 0) && ({2'b00, bus.req_addr} >= ADDR_LIMIT);
  assign accept_err = req_bad(bus.req_we, bus.req_funct3, bus.req_addr[1:0]) | range_err;

  lsu_align u_align (
    .rdata      (bus.mem_rdata),
    .lane       (lane_q),
    .funct3     (f3_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      we_q         <= 1'b0;
      f3_q         <= '0;
      lane_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_trig_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      mem_trig_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            we_q         <= bus.req_we;
            f3_q         <= bus.req_funct3;
            lane_q       <= bus.req_addr[1:0];
            wdata_q      <= bus.req_wdata;
            resp_rdata_q <= '0;
            resp_err_q   <= accept_err;
            if (accept_err) begin
              resp_valid_q <= 1'b1;
              state        <= S_RESP;
            end else if (bus.req_we && bus.req_funct3 == F3_W) begin
              mem_trig_q  <= 1'b1;
              mem_write_q <= 1'b1;
              mem_addr_q  <= bus.req_addr >> WORD_SHIFT;
              mem_wdata_q <= bus.req_wdata;
              state       <= S_WR;
            end else begin
              mem_trig_q <= 1'b1;
              mem_read_q <= 1'b1;
              mem_addr_q <= bus.req_addr >> WORD_SHIFT;
              state      <= S_RD_REQ;
            end
          end
        end
        S_RD_REQ: state <= S_RD_DATA;
        S_RD_DATA: begin
          if (we_q) begin
            mem_trig_q  <= 1'b1;
            mem_write_q <= 1'b1;
            mem_wdata_q <= store_word;
            state       <= S_WR;
          end else begin
            resp_rdata_q <= load_data;
            resp_valid_q <= 1'b1;
            state        <= S_RESP;
          end
        end
        S_WR: begin
          resp_valid_q <= 1'b1;
          state        <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_trig   = mem_trig_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: word-addressed memory model with registered read,
// and a shadow-memory reference model of RV32I load/store semantics.
module tb_load_store_unit;
  import lsu_pkg::*;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [7:0]  lat;
    logic [7:0]  nrd;
    logic [7:0]  nwr;
    logic [7:0]  ntrig;
    logic [31:0] rd_addr;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
  } obs_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] lit_rdata;
    logic [7:0]  lit_lat;
  } dir_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  logic [31:0] mem [512];
  logic [31:0] ref_mem [512];

  int unsigned rd_tot = 0, wr_tot = 0, trig_tot = 0, resp_tot = 0, both_tot = 0, stray_tot = 0;
  logic [31:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;

  lsu_if bus ();

  load_store_unit #(.WIDTH(32), .MEM_WORDS(512), .RANGE_CHECK(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_trig && bus.mem_read) bus.mem_rdata <= mem[bus.mem_addr[8:0]];
    if (bus.mem_trig && bus.mem_write) mem[bus.mem_addr[8:0]] <= bus.mem_wdata;
  end

  always @(posedge clk) begin
    if (bus.mem_trig) trig_tot++;
    if (bus.mem_trig && bus.mem_read) begin rd_tot++; last_rd_addr = bus.mem_addr; end
    if (bus.mem_trig && bus.mem_write) begin
      wr_tot++; last_wr_addr = bus.mem_addr; last_wr_data = bus.mem_wdata;
    end
    if (bus.mem_read && bus.mem_write) both_tot++;
    if (!bus.mem_trig && (bus.mem_read || bus.mem_write)) stray_tot++;
    if (bus.resp_valid) resp_tot++;
  end

  function automatic obs_t model_op(input logic we, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] wd);
    obs_t e;
    logic [31:0] word, v, mask;
    int unsigned lane, idx;
    bit bad;
    e = '0;
    lane = addr % 4;
    idx = addr / 4;
    bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4) ||
          ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) || (f3 == 3'd2 && lane != 0) ||
          (addr >= 32'd2048);
    if (bad) begin
      e.err = 1'b1;
      e.lat = 8'd1;
      return e;
    end
    word = ref_mem[idx];
    if (!we) begin
      e.lat = 8'd3; e.nrd = 8'd1; e.ntrig = 8'd1; e.rd_addr = idx;
      v = word >> (8 * lane);
      case (f3)
        3'd0: begin v = v & 32'd255;   if (v >= 32'd128)   v = v - 32'd256;   end
        3'd1: begin v = v & 32'd65535; if (v >= 32'd32768) v = v - 32'd65536; end
        3'd4: v = v & 32'd255;
        3'd5: v = v & 32'd65535;
        default: v = word;
      endcase
      e.rdata = v;
    end else begin
      e.nwr = 8'd1; e.wr_addr = idx;
      if (f3 == 3'd2) begin
        e.lat = 8'd2; e.ntrig = 8'd1; word = wd;
      end else begin
        e.lat = 8'd4; e.nrd = 8'd1; e.ntrig = 8'd2; e.rd_addr = idx;
        mask = (f3 == 3'd0) ? 32'd255 : 32'd65535;
        word = (word & ~(mask << (8 * lane))) | ((wd & mask) << (8 * lane));
      end
      e.wr_data = word;
      ref_mem[idx] = word;
    end
    return e;
  endfunction

  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output obs_t got);
    int w, lat;
    int unsigned rd0, wr0, tr0;
    @(negedge clk);
    w = 0;
    while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
    rd0 = rd_tot; wr0 = wr_tot; tr0 = trig_tot;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_we = 1'($urandom); bus.req_funct3 = 3'($urandom);
    bus.req_addr = $urandom; bus.req_wdata = $urandom;
    lat = 1;
    while (!bus.resp_valid && lat < 12) begin @(negedge clk); lat++; end
    got = '0;
    got.err = bus.resp_err;
    got.rdata = bus.resp_rdata;
    got.lat = 8'(lat);
    got.nrd = 8'(rd_tot - rd0);
    got.nwr = 8'(wr_tot - wr0);
    got.ntrig = 8'(trig_tot - tr0);
    if (rd_tot != rd0) got.rd_addr = last_rd_addr;
    if (wr_tot != wr0) begin got.wr_addr = last_wr_addr; got.wr_data = last_wr_data; end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: ready=%b resp_valid=%b err=%b, required 1 0 0",
               bus.req_ready, bus.resp_valid, bus.resp_err);
    end
    vectors++;
    if (bus.resp_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h, required 00000000", bus.resp_rdata);
    end
    vectors++;
    if ({bus.mem_trig, bus.mem_read, bus.mem_write} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b, required 000", {bus.mem_trig, bus.mem_read, bus.mem_write});
    end
    vectors++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mem_bus: addr=%h wdata=%h, required 0 0", bus.mem_addr, bus.mem_wdata);
    end
  endtask

  task automatic test_directed;
    dir_t tbl [10];
    obs_t got, exp;
    tbl[0] = '{1'b0, 3'd2, 32'h14,  32'h0,        32'h0000_0005, 8'd3};
    tbl[1] = '{1'b1, 3'd2, 32'h20,  32'hDEADBEEF, 32'h0,         8'd2};
    tbl[2] = '{1'b0, 3'd2, 32'h20,  32'h0,        32'hDEADBEEF,  8'd3};
    tbl[3] = '{1'b1, 3'd0, 32'h21,  32'h55,       32'h0,         8'd4};
    tbl[4] = '{1'b0, 3'd0, 32'h23,  32'h0,        32'hFFFFFFDE,  8'd3};
    tbl[5] = '{1'b0, 3'd4, 32'h23,  32'h0,        32'h000000DE,  8'd3};
    tbl[6] = '{1'b0, 3'd1, 32'h22,  32'h0,        32'hFFFFDEAD,  8'd3};
    tbl[7] = '{1'b0, 3'd1, 32'h13,  32'h0,        32'h0,         8'd1};
    tbl[8] = '{1'b1, 3'd2, 32'h0A,  32'h12345678, 32'h0,         8'd1};
    tbl[9] = '{1'b0, 3'd2, 32'h800, 32'h0,        32'h0,         8'd1};
    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, got);
      exp = model_op(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL directed_%0d: got err=%b rdata=%h lat=%0d rd=%0d wr=%0d trig=%0d rda=%0d wra=%0d wrd=%h, required err=%b rdata=%h lat=%0d rd=%0d wr=%0d trig=%0d rda=%0d wra=%0d wrd=%h",
                 i, got.err, got.rdata, got.lat, got.nrd, got.nwr, got.ntrig, got.rd_addr, got.wr_addr, got.wr_data,
                 exp.err, exp.rdata, exp.lat, exp.nrd, exp.nwr, exp.ntrig, exp.rd_addr, exp.wr_addr, exp.wr_data);
      end
      vectors++;
      if (got.rdata !== tbl[i].lit_rdata || got.lat !== tbl[i].lit_lat) begin
        miscompares++;
        $display("FAIL directed_lit_%0d: got rdata=%h lat=%0d, required rdata=%h lat=%0d",
                 i, got.rdata, got.lat, tbl[i].lit_rdata, tbl[i].lit_lat);
      end
      if (i == 3) begin
        vectors++;
        if (got.wr_data !== 32'hDEAD55EF || got.wr_addr !== 32'd8) begin
          miscompares++;
          $display("FAIL sb_merge: got word %0d = %h, required word 8 = dead55ef", got.wr_addr, got.wr_data);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int unsigned wr0, rv0;
    @(negedge clk);
    while (!bus.req_ready) @(negedge clk);
    wr0 = wr_tot; rv0 = resp_tot;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h21; bus.req_wdata = 32'hAA;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (dut.state !== S_IDLE || bus.req_ready !== 1'b1 || bus.mem_trig !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_state: state=%0d ready=%b trig=%b, required IDLE 1 0",
               dut.state, bus.req_ready, bus.mem_trig);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    vectors++;
    if (wr_tot != wr0 || resp_tot != rv0) begin
      miscompares++;
      $display("FAIL reset_mid_drop: writes=%0d responses=%0d, required 0 0", wr_tot - wr0, resp_tot - rv0);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_q [$];
    int acc [$];
    int c, issued, done;
    logic [31:0] a, e;
    obs_t m;
    @(negedge clk);
    issued = 0; done = 0; c = 0;
    while (done < 4 && c < 60) begin
      if (bus.resp_valid) begin
        e = exp_q.pop_front();
        vectors++;
        if (bus.resp_rdata !== e || bus.resp_err !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_data_%0d: got %h err=%b, required %h err=0", done, bus.resp_rdata, bus.resp_err, e);
        end
        done++;
      end
      if (bus.req_ready && issued < 4) begin
        a = 32'($urandom_range(0, 511)) << 2;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2;
        bus.req_addr = a; bus.req_wdata = $urandom;
        m = model_op(1'b0, 3'd2, a, 32'h0);
        exp_q.push_back(m.rdata);
        acc.push_back(c);
        issued++;
      end else begin
        bus.req_valid = (issued < 4);
        bus.req_we = 1'($urandom); bus.req_funct3 = 3'($urandom);
        bus.req_addr = $urandom; bus.req_wdata = $urandom;
      end
      @(negedge clk);
      c++;
    end
    bus.req_valid = 1'b0;
    vectors++;
    if (done != 4) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d responses, required 4", done);
    end
    for (int i = 1; i < acc.size(); i++) begin
      vectors++;
      if (acc[i] - acc[i-1] != 4) begin
        miscompares++;
        $display("FAIL b2b_spacing_%0d: got %0d cycles, required 4", i, acc[i] - acc[i-1]);
      end
    end
  endtask

  task automatic test_random;
    obs_t got, exp;
    logic we;
    logic [2:0] f3;
    logic [31:0] addr, wd;
    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom);
      f3 = 3'($urandom);
      if ($urandom_range(0, 9) == 0) addr = $urandom_range(2000, 2200);
      else addr = $urandom_range(0, 127);
      if ($urandom_range(0, 1) == 1) addr = (f3[1:0] == 2'd2) ? (addr & ~32'd3) :
                                            (f3[1:0] == 2'd1) ? (addr & ~32'd1) : addr;
      wd = $urandom;
      do_op(we, f3, addr, wd, got);
      exp = model_op(we, f3, addr, wd);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL random_%0d (we=%b f3=%0d addr=%h wd=%h): got err=%b rdata=%h lat=%0d rd=%0d wr=%0d trig=%0d wrd=%h, required err=%b rdata=%h lat=%0d rd=%0d wr=%0d trig=%0d wrd=%h",
                 i, we, f3, addr, wd, got.err, got.rdata, got.lat, got.nrd, got.nwr, got.ntrig, got.wr_data,
                 exp.err, exp.rdata, exp.lat, exp.nrd, exp.nwr, exp.ntrig, exp.wr_data);
      end
    end
  endtask

  task automatic test_strobes;
    vectors++;
    if (both_tot != 0) begin
      miscompares++;
      $display("FAIL read_write_overlap: got %0d cycles, required 0", both_tot);
    end
    vectors++;
    if (stray_tot != 0) begin
      miscompares++;
      $display("FAIL strobe_without_trig: got %0d cycles, required 0", stray_tot);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i] = 32'(i);
      ref_mem[i] = 32'(i);
    end
    test_reset();
    test_directed();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_strobes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
